// File: rtl/simon_seq_player.sv
`default_nettype none
// ============================================================================
// Module   : simon_seq_player
// Purpose  : Colour-sequence store, random generator and playback engine for
//            the Simon game. The game FSM clears the sequence, appends random
//            colours, replays the sequence and checks each player press.
// Revision : 1.0 - initial release
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   Clear        in   empty the sequence, abort playback (any state)
//   Append       in   add one random colour (IDLE only)
//   Play         in   start playback (IDLE only)
//   Check_valid  in   player press present (IDLE only)
//   Check_color  in   pressed colour: 0 red, 1 blue, 2 yellow, 3 green
//   Color_valid  out  playback colour lit
//   Color_out    out  colour being shown, 0 when dark
//   Busy         out  playback in progress
//   Play_done    out  one-cycle pulse at end of playback
//   Length       out  current sequence length
//   Full         out  Length == MAX_LEN
//   Check_resp   out  one-cycle pulse answering a check
//   Check_match  out  result of the last check (held)
//   Check_last   out  last check matched the final entry (held)
//
// Build option
//   SIMON_NO_REPEAT_EN : when defined, an appended colour that equals the
//                        previous entry is bumped by one (mod 4).
// ============================================================================
module simon_seq_player #(
    parameter int          MAX_LEN   = 32,
    parameter int          ON_TICKS  = 25_000_000,
    parameter int          OFF_TICKS = 12_500_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             Append,
    input  logic             Play,
    input  logic             Check_valid,
    input  logic [1:0]       Check_color,
    output logic             Color_valid,
    output logic [1:0]       Color_out,
    output logic             Busy,
    output logic             Play_done,
    output logic [LEN_W-1:0] Length,
    output logic             Full,
    output logic             Check_resp,
    output logic             Check_match,
    output logic             Check_last
);

    localparam int IDX_W     = $clog2(MAX_LEN);
    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0]       SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY_ON  = 2'd1,
        PLAY_OFF = 2'd2
    } state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [1:0]        seq [MAX_LEN];
    logic [IDX_W-1:0]  play_idx;
    logic [IDX_W-1:0]  check_idx;
    logic [TICK_W-1:0] tick;

    logic              lfsr_fb;
    logic              append_go;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  next_play;
    logic [1:0]        new_color;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign Busy      = (state != IDLE);
    assign Full      = (Length == LEN_MAX);
    assign append_go = (state == IDLE) && !Clear && Append && !Full;
    assign wr_idx    = Length[IDX_W-1:0];
    assign last_idx  = IDX_W'(Length - LEN_W'(1));
    assign next_play = play_idx + IDX_W'(1);

`ifdef SIMON_NO_REPEAT_EN
    assign new_color = ((Length != '0) && (lfsr[1:0] == seq[last_idx]))
                     ? (lfsr[1:0] + 2'd1) : lfsr[1:0];
`else
    assign new_color = lfsr[1:0];
`endif

    // Sequence storage needs no reset: Length defines which entries are live.
    always_ff @(posedge Clk) begin
        if (append_go) begin
            seq[wr_idx] <= new_color;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            lfsr        <= SEED;
            Length      <= '0;
            play_idx    <= '0;
            check_idx   <= '0;
            tick        <= '0;
            Color_valid <= 1'b0;
            Color_out   <= 2'd0;
            Play_done   <= 1'b0;
            Check_resp  <= 1'b0;
            Check_match <= 1'b0;
            Check_last  <= 1'b0;
        end else begin
            lfsr       <= {lfsr_fb, lfsr[15:1]};
            Play_done  <= 1'b0;
            Check_resp <= 1'b0;
            if (Clear) begin
                state       <= IDLE;
                Length      <= '0;
                play_idx    <= '0;
                check_idx   <= '0;
                tick        <= '0;
                Color_valid <= 1'b0;
                Color_out   <= 2'd0;
                Check_match <= 1'b0;
                Check_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Append) begin
                            if (!Full) begin
                                Length <= Length + LEN_W'(1);
                            end
                        end else if (Play) begin
                            check_idx <= '0;
                            play_idx  <= '0;
                            tick      <= '0;
                            if (Length != '0) begin
                                state       <= PLAY_ON;
                                Color_valid <= 1'b1;
                                Color_out   <= seq[0];
                            end else begin
                                Play_done <= 1'b1;
                            end
                        end else if (Check_valid) begin
                            Check_resp <= 1'b1;
                            if ((Length != '0) && (Check_color == seq[check_idx])) begin
                                Check_match <= 1'b1;
                                if (check_idx == last_idx) begin
                                    Check_last <= 1'b1;
                                    check_idx  <= '0;
                                end else begin
                                    Check_last <= 1'b0;
                                    check_idx  <= check_idx + IDX_W'(1);
                                end
                            end else begin
                                Check_match <= 1'b0;
                                Check_last  <= 1'b0;
                                check_idx   <= '0;
                            end
                        end
                    end
                    PLAY_ON: begin
                        if (tick == ON_LAST) begin
                            tick        <= '0;
                            state       <= PLAY_OFF;
                            Color_valid <= 1'b0;
                            Color_out   <= 2'd0;
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                    PLAY_OFF: begin
                        if (tick == OFF_LAST) begin
                            tick <= '0;
                            if (play_idx == last_idx) begin
                                state     <= IDLE;
                                Play_done <= 1'b1;
                            end else begin
                                play_idx    <= next_play;
                                state       <= PLAY_ON;
                                Color_valid <= 1'b1;
                                Color_out   <= seq[next_play];
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_seq_player
// Purpose  : Self-checking bench for simon_seq_player. A bench-side LFSR and
//            sequence model predict every stored colour; played colours are
//            pushed to a scoreboard queue when Play is driven and popped as
//            each colour lights up.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_seq_player;

    localparam int          MAX_LEN = 4;
    localparam int          ON      = 4;
    localparam int          OFF     = 2;
    localparam logic [15:0] SEED    = 16'h0001;
    localparam int          LW      = $clog2(MAX_LEN + 1);

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Clear = 1'b0;
    logic          Append = 1'b0;
    logic          Play = 1'b0;
    logic          Check_valid = 1'b0;
    logic [1:0]    Check_color = 2'd0;
    logic          Color_valid;
    logic [1:0]    Color_out;
    logic          Busy;
    logic          Play_done;
    logic [LW-1:0] Length;
    logic          Full;
    logic          Check_resp;
    logic          Check_match;
    logic          Check_last;

    simon_seq_player #(
        .MAX_LEN   (MAX_LEN),
        .ON_TICKS  (ON),
        .OFF_TICKS (OFF),
        .LFSR_SEED (SEED)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Clear       (Clear),
        .Append      (Append),
        .Play        (Play),
        .Check_valid (Check_valid),
        .Check_color (Check_color),
        .Color_valid (Color_valid),
        .Color_out   (Color_out),
        .Busy        (Busy),
        .Play_done   (Play_done),
        .Length      (Length),
        .Full        (Full),
        .Check_resp  (Check_resp),
        .Check_match (Check_match),
        .Check_last  (Check_last)
    );

    always #5 Clk = ~Clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  m_seq[$];
    logic [1:0]  exp_q[$];

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Fibonacci, right shift.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) m_lfsr <= SEED;
        else          m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [1:0] model_color();
        logic [1:0] c;
        c = m_lfsr[1:0];
`ifdef SIMON_NO_REPEAT_EN
        if (m_seq.size() > 0 && c == m_seq[m_seq.size()-1]) c = c + 2'd1;
`endif
        return c;
    endfunction

    task automatic drive_append();
        if (m_seq.size() < MAX_LEN) m_seq.push_back(model_color());
        Append = 1'b1;
        step();
        Append = 1'b0;
    endtask

    task automatic drive_clear();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        m_seq.delete();
    endtask

    // Plays the modelled sequence and checks timing and colours cycle by cycle.
    task automatic test_playback(input string tag);
        int         period;
        int         total;
        logic [1:0] cur;
        logic [1:0] exp_out;
        logic       prev_cv;
        logic [2:0] exp_ctl;
`ifdef SIMON_NO_REPEAT_EN
        logic [1:0] prev_col;
        bit         have_prev;
        have_prev = 1'b0;
        prev_col  = 2'd0;
`endif
        period  = ON + OFF;
        total   = m_seq.size() * period;
        cur     = 2'd0;
        prev_cv = 1'b0;
        foreach (m_seq[i]) exp_q.push_back(m_seq[i]);
        Play = 1'b1;
        step();
        Play = 1'b0;
        for (int c = 1; c <= total + 1; c++) begin
            exp_ctl = {c <= total, (c <= total) && (((c - 1) % period) < ON), c == total + 1};
            n_cmp++;
            if ({Busy, Color_valid, Play_done} !== exp_ctl) begin
                n_err++;
                $display("FAIL %s busy/valid/done cycle %0d: got %b want %b", tag, c,
                         {Busy, Color_valid, Play_done}, exp_ctl);
            end
            if (Color_valid && !prev_cv) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra colour cycle %0d: got %0d want none", tag, c, Color_out);
                end else begin
                    cur = exp_q.pop_front();
                    if (Color_out !== cur) begin
                        n_err++;
                        $display("FAIL %s colour cycle %0d: got %0d want %0d", tag, c, Color_out, cur);
                    end
                end
`ifdef SIMON_NO_REPEAT_EN
                if (have_prev) begin
                    n_cmp++;
                    if (Color_out === prev_col) begin
                        n_err++;
                        $display("FAIL %s repeat cycle %0d: got %0d twice want different", tag, c, Color_out);
                    end
                end
                prev_col  = Color_out;
                have_prev = 1'b1;
`endif
            end else begin
                exp_out = Color_valid ? cur : 2'd0;
                n_cmp++;
                if (Color_out !== exp_out) begin
                    n_err++;
                    $display("FAIL %s colour hold cycle %0d: got %0d want %0d", tag, c, Color_out, exp_out);
                end
            end
            prev_cv = Color_valid;
            step();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s missing colours: got %0d left want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({Color_valid, Color_out, Busy, Play_done, Full, Check_resp, Check_match, Check_last} !== 9'd0) begin
            n_err++;
            $display("FAIL reset outputs: got %b want 0",
                     {Color_valid, Color_out, Busy, Play_done, Full, Check_resp, Check_match, Check_last});
        end
        n_cmp++;
        if (Length !== '0) begin
            n_err++;
            $display("FAIL reset length: got %0d want 0", Length);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_append_seq();
        for (int i = 0; i < 3; i++) begin
            drive_append();
            n_cmp++;
            if (Length !== LW'(i + 1)) begin
                n_err++;
                $display("FAIL append length %0d: got %0d want %0d", i, Length, i + 1);
            end
        end
        test_playback("append3");
    endtask

    task automatic test_full();
        drive_clear();
        for (int i = 0; i < 6; i++) begin
            drive_append();
            n_cmp++;
            if ({Length, Full} !== {LW'((i < MAX_LEN) ? i + 1 : MAX_LEN), (i >= MAX_LEN - 1)}) begin
                n_err++;
                $display("FAIL full step %0d: got len %0d full %b want len %0d full %b", i, Length, Full,
                         (i < MAX_LEN) ? i + 1 : MAX_LEN, i >= MAX_LEN - 1);
            end
        end
        test_playback("full");
    endtask

    task automatic test_check();
        logic [1:0] col[7];
        logic [2:0] want[7];
        drive_clear();
        for (int i = 0; i < 3; i++) drive_append();
        // resp/match/last after each press
        col[0] = m_seq[0];         want[0] = 3'b110;
        col[1] = m_seq[1];         want[1] = 3'b110;
        col[2] = m_seq[2];         want[2] = 3'b111;
        col[3] = m_seq[0] ^ 2'd1;  want[3] = 3'b100;
        col[4] = m_seq[0];         want[4] = 3'b110;
        col[5] = m_seq[1] ^ 2'd2;  want[5] = 3'b100;
        col[6] = m_seq[0];         want[6] = 3'b110;
        for (int i = 0; i < 7; i++) begin
            Check_valid = 1'b1;
            Check_color = col[i];
            step();
            Check_valid = 1'b0;
            n_cmp++;
            if ({Check_resp, Check_match, Check_last} !== want[i]) begin
                n_err++;
                $display("FAIL check %0d: got %b want %b", i, {Check_resp, Check_match, Check_last}, want[i]);
            end
            step();
            n_cmp++;
            if ({Check_resp, Check_match, Check_last} !== {1'b0, want[i][1:0]}) begin
                n_err++;
                $display("FAIL check hold %0d: got %b want %b", i, {Check_resp, Check_match, Check_last},
                         {1'b0, want[i][1:0]});
            end
        end
        drive_clear();
        n_cmp++;
        if ({Check_resp, Check_match, Check_last} !== 3'b000) begin
            n_err++;
            $display("FAIL check clear: got %b want 000", {Check_resp, Check_match, Check_last});
        end
        Check_valid = 1'b1;
        Check_color = 2'd0;
        step();
        Check_valid = 1'b0;
        n_cmp++;
        if ({Check_resp, Check_match, Check_last} !== 3'b100) begin
            n_err++;
            $display("FAIL check empty: got %b want 100", {Check_resp, Check_match, Check_last});
        end
    endtask

    task automatic test_clear_mid_play();
        drive_clear();
        for (int i = 0; i < 3; i++) drive_append();
        Play = 1'b1;
        step();
        Play = 1'b0;
        for (int c = 1; c < 8; c++) step();
        n_cmp++;
        if (Color_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midclear lit at cycle 8: got %b want 1", Color_valid);
        end
        drive_clear();
        n_cmp++;
        if ({Busy, Color_valid, Color_out, Play_done, Length} !== '0) begin
            n_err++;
            $display("FAIL midclear cycle 9: got busy %b valid %b col %0d done %b len %0d want all 0",
                     Busy, Color_valid, Color_out, Play_done, Length);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if ({Busy, Play_done} !== 2'b00) begin
                n_err++;
                $display("FAIL midclear after %0d: got busy/done %b want 00", c, {Busy, Play_done});
            end
        end
        test_playback("empty");
    endtask

    task automatic test_priority();
        drive_clear();
        m_seq.push_back(model_color());
        Append = 1'b1;
        Play = 1'b1;
        step();
        Append = 1'b0;
        Play = 1'b0;
        n_cmp++;
        if ({Length, Busy, Play_done} !== {LW'(1), 2'b00}) begin
            n_err++;
            $display("FAIL prio append>play: got len %0d busy %b done %b want 1 0 0", Length, Busy, Play_done);
        end
        Clear = 1'b1;
        Append = 1'b1;
        step();
        Clear = 1'b0;
        Append = 1'b0;
        m_seq.delete();
        n_cmp++;
        if (Length !== '0) begin
            n_err++;
            $display("FAIL prio clear>append: got %0d want 0", Length);
        end
        Play = 1'b1;
        Check_valid = 1'b1;
        step();
        Play = 1'b0;
        Check_valid = 1'b0;
        n_cmp++;
        if ({Play_done, Check_resp} !== 2'b10) begin
            n_err++;
            $display("FAIL prio play>check: got %b want 10", {Play_done, Check_resp});
        end
    endtask

    task automatic test_back_to_back();
        int c;
        drive_clear();
        drive_append();
        drive_append();
        Play = 1'b1;
        step();
        Play = 1'b0;
        Append = 1'b1;
        step();
        Append = 1'b0;
        Check_valid = 1'b1;
        step();
        Check_valid = 1'b0;
        n_cmp++;
        if ({Length, Check_resp} !== {LW'(2), 1'b0}) begin
            n_err++;
            $display("FAIL busy ignore: got len %0d resp %b want 2 0", Length, Check_resp);
        end
        c = 3;
        while (!Play_done && c < 40) begin
            step();
            c++;
        end
        n_cmp++;
        if (c !== 2 * (ON + OFF) + 1) begin
            n_err++;
            $display("FAIL play_done cycle: got %0d want %0d", c, 2 * (ON + OFF) + 1);
        end
        // Play_done cycle already accepts a new command.
        Play = 1'b1;
        step();
        Play = 1'b0;
        n_cmp++;
        if ({Busy, Color_valid, Color_out} !== {2'b11, m_seq[0]}) begin
            n_err++;
            $display("FAIL back-to-back start: got %b %b %0d want 1 1 %0d", Busy, Color_valid, Color_out, m_seq[0]);
        end
        c = 1;
        while (!Play_done && c < 40) begin
            step();
            c++;
        end
        n_cmp++;
        if (c !== 2 * (ON + OFF) + 1) begin
            n_err++;
            $display("FAIL back-to-back done cycle: got %0d want %0d", c, 2 * (ON + OFF) + 1);
        end
        step();
    endtask

    task automatic test_reset_mid_play();
        drive_clear();
        drive_append();
        drive_append();
        Play = 1'b1;
        step();
        Play = 1'b0;
        step();
        step();
        #2;
        Reset_n = 1'b0;
        #1;
        m_seq.delete();
        n_cmp++;
        if ({Busy, Color_valid, Color_out, Length} !== '0) begin
            n_err++;
            $display("FAIL async reset: got busy %b valid %b col %0d len %0d want 0", Busy, Color_valid,
                     Color_out, Length);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if ({Busy, Play_done} !== 2'b00) begin
                n_err++;
                $display("FAIL after reset %0d: got busy/done %b want 00", c, {Busy, Play_done});
            end
        end
    endtask

    task automatic test_random();
        for (int g = 0; g < 50; g++) begin
            drive_clear();
            for (int k = 0; k < MAX_LEN; k++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int j = 0; j < gap; j++) step();
                drive_append();
            end
            n_cmp++;
            if (Length !== LW'(MAX_LEN)) begin
                n_err++;
                $display("FAIL random len group %0d: got %0d want %0d", g, Length, MAX_LEN);
            end
            test_playback("random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_append_seq();
        test_full();
        test_check();
        test_clear_mid_play();
        test_priority();
        test_back_to_back();
        test_reset_mid_play();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_seq_player.md
# simon_seq_player

Color-sequence generator, store and playback engine for the Simon game. Sits directly beside the game state machine: the game FSM commands it to clear, append a random color, replay the sequence and check each player button press. Playback drives the display path (VGA/LEDs) through a valid/color output. Randomness comes from a free-running LFSR, so sequences depend on player timing.

## Interface

- MAX_LEN, 32: sequence depth in entries, range 2–64.
- ON_TICKS, 25_000_000: clock cycles each color stays lit during playback, ≥1.
- OFF_TICKS, 12_500_000: dark gap cycles after each color, ≥1.
- LFSR_SEED, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.

- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Clear  in  1  empty the sequence and abort playback; accepted in any state.
- Append  in  1  add one random color; accepted in IDLE only.
- Play  in  1  start playback; accepted in IDLE only.
- Check_valid  in  1  player press present; accepted in IDLE only.
- Check_color  in  2  pressed color: 0 red (U), 1 blue (R), 2 yellow (D), 3 green (L).
- Color_valid  out  1  playback color lit.
- Color_out  out  2  color being shown; 0 when Color_valid=0.
- Busy  out  1  playback in progress.
- Play_done  out  1  one-cycle pulse when playback finishes.
- Length  out  $clog2(MAX_LEN+1)  current sequence length.
- Full  out  1  Length == MAX_LEN.
- Check_resp  out  1  one-cycle pulse answering a check.
- Check_match  out  1  registered result of the last check.
- Check_last  out  1  the last check matched the final entry.

## Operation

- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. It advances every cycle, including during reset release and playback. The new color is lfsr[1:0].
- FSM states: IDLE, PLAY_ON, PLAY_OFF.
- In IDLE, command priority is Clear > Append > Play > Check_valid. Lower-priority inputs asserted in the same cycle are dropped.
- Clear: Length←0, check index←0. From PLAY_ON or PLAY_OFF it also forces IDLE with no Play_done.
- Append: seq[Length]←color, Length←Length+1. When Full, Append is ignored and nothing changes.
- Play with Length>0: enter PLAY_ON with play index 0. Each entry is shown for ON_TICKS cycles in PLAY_ON, then OFF_TICKS cycles in PLAY_OFF. After the last entry's OFF phase, return to IDLE and pulse Play_done. The check index resets to 0 when Play is accepted.
- Play with Length=0: stay in IDLE and pulse Play_done the next cycle.
- Check:
  - Compare Check_color with seq[check index].
  - On a match, index+1. If the index was Length−1, set Check_last=1 and index←0.
  - On a mismatch, Check_match=0 and index←0.
  - With Length=0 the result is always a mismatch.
- Append, Play and Check_valid while Busy are ignored.

## Timing

- Reset values: state IDLE, lfsr=LFSR_SEED, Length=0, all indices 0. All outputs 0 except Length=0 and Full=0.
- A command is sampled at rising edge N. Its effect (Length, Busy, Color_valid) is visible in cycle N+1.
- Check_resp, Check_match and Check_last are valid in cycle N+1 after Check_valid at edge N. Check_match and Check_last hold until the next check or Clear, which zeroes them.
- Play accepted at edge 0: Busy is high for cycles 1..L·(ON_TICKS+OFF_TICKS). Play_done is high in the following cycle, with Busy=0 and new commands accepted that cycle.
- Color_valid and Color_out are registered. There is no combinational path from inputs to outputs.
- Tick counter width is $clog2(max(ON_TICKS,OFF_TICKS)). Index wrap is explicit; there is no modulo overflow beyond MAX_LEN.
- Reset_n asserted mid-playback clears everything immediately, asynchronously. Outputs go low without a Play_done.

## Configuration

- SIMON_NO_REPEAT_EN defined: on Append with Length>0, if lfsr[1:0] equals seq[Length−1], the stored color is (lfsr[1:0]+1) mod 4. No extra cycle is used.
- Not defined: lfsr[1:0] is stored unmodified, and consecutive repeats are allowed.

## Test plan

- Reset with LFSR_SEED=16'h0001, then three Appends on consecutive cycles → Length 1,2,3 in cycles 1–3. Stored colors equal a bench LFSR model's lfsr[1:0] at each sampling edge.
- ON_TICKS=4, OFF_TICKS=2, Length=3, Play at edge 0 → Color_valid high cycles 1–4, 7–10, 13–16 with the stored colors. Busy high cycles 1–18; Play_done high only in cycle 19.
- MAX_LEN=4, six Appends → Length saturates at 4, Full=1, and seq[0..3] are unchanged by the extra Appends.
- Length=3, check the correct colors in order → three Check_resp pulses, Check_match=1 each time, Check_last=1 only on the third. Then check a wrong color → Check_match=0, index back to 0.
- Clear asserted in cycle 8 of playback → Busy=0 and Color_valid=0 in cycle 9, Length=0, no Play_done. Play then pulses Play_done next cycle with no colors shown.
- With SIMON_NO_REPEAT_EN, 200 Appends over random gaps → no two adjacent stored colors are equal. Without the macro, the LFSR model matches exactly.
